i2s_capture_ctrl: RTL and testbench
===================================

# i2s_capture_ctrl

Sequencing and buffering controller for the `i2s_rx` receiver in the TinyML SoC audio front end. It watches the receiver's `ws` line, captures each completed 64-bit stereo frame from `rx_data`, and applies channel selection and frame decimation. Selected 24-bit samples go into a small FIFO that the Hazard2 CPU or a DMA master drains through a valid/ready port, with level and overflow flags for interrupt generation.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 4.
- `CNT_W`, 4: width of `fifo_count`; equals log2(`DEPTH`)+1.

Ports:
- `clk` in 1: system clock; `i2s_rx` derives `i2s_clk` from the same clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: capture enable.
- `ch_mode` in 2: 0 = ch0 only; 1 = ch1 only; 2 = both channels; 3 = reserved, treated as 0.
- `decim` in 4: keep 1 frame in every `decim`+1 frames.
- `thresh` in CNT_W: FIFO level threshold.
- `flush` in 1: single-cycle pulse that empties the FIFO.
- `clr_ovf` in 1: single-cycle pulse that clears `ovf`.
- `ws` in 1: word select from `i2s_rx`.
- `rx_data` in 64: frame from `i2s_rx`. [31:0] is ch0 (the ws=1 half); [63:32] is ch1.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out 24: sample.
- `out_ch` out 1: channel tag of the sample.
- `fifo_count` out CNT_W: current occupancy.
- `level_irq` out 1: high while `fifo_count` ≥ `thresh` and `thresh` ≠ 0.
- `ovf` out 1: sticky overflow flag.
- `busy` out 1: high while the state is not IDLE.

## Operation
- Frame edge: register `ws` into `ws_q`. `frame_done` = `ws` & ~`ws_q`. `rx_data` holds the complete previous frame in the cycle `frame_done` is high.
- Sample extraction: ch0 = `rx_data[23:0]`, ch1 = `rx_data[55:32]`. Bits [31:24] and [63:56] are ignored.
- State machine:
  - IDLE → SYNC when `en`=1.
  - SYNC: discard the first `frame_done` (it is a partial frame), load `dcnt`=0, go to RUN.
  - RUN: on `frame_done`:
    - If `dcnt`≠0: decrement `dcnt` and drop the frame.
    - If `dcnt`=0: reload `dcnt`=`decim` and keep the frame.
    - Kept frame, mode 0 or 1: push the selected channel.
    - Kept frame, mode 2: push ch0, latch ch1, go to PUSH2.
  - PUSH2: push the latched ch1 (tag 1), return to RUN.
  - Any state → IDLE in the cycle after `en` is sampled 0. An in-flight PUSH2 still completes before entering IDLE.
- Config sampling: `ch_mode` and `decim` are sampled at each kept frame. Changes while running take effect at the next reload.
- FIFO:
  - Circular buffer of 25-bit entries {ch, data}; `DEPTH` entries.
  - Pointers are log2(`DEPTH`) bits wide and wrap naturally.
  - `count` is a separate register.
- Push when full: the entry is dropped and `ovf` is set. Full is evaluated on the registered count, so a simultaneous pop does not rescue the push.
- Pop: occurs when `out_valid` & `out_ready`.
- Simultaneous push and pop with no overflow: `count` is unchanged.
- `flush`: zeroes pointers and `count` next cycle and overrides a same-cycle push or pop. It does not touch `ovf` or the state.
- `clr_ovf`: clears `ovf`. A same-cycle overflow wins, leaving `ovf`=1.
- `out_data`/`out_ch` show the FIFO head combinationally. They are don't-care when `out_valid`=0.

## Timing
- Reset values:
  - State IDLE; `ws_q`=0; `dcnt`=0.
  - Pointers 0; `count` 0.
  - Outputs: `out_valid`=0, `out_data`=0, `out_ch`=0, `fifo_count`=0, `level_irq`=0, `ovf`=0, `busy`=0.
- Latency: `ws` rise at clk edge N → `frame_done` at N → entry written at edge N+1 → `out_valid` high after edge N+1.
- Mode 2: the ch1 entry is written at N+2.
- Minimum `ws` period: 64 `i2s_clk` periods, which is far more than 2 clk. Back-to-back `frame_done` within PUSH2 cannot occur.
- `level_irq` and `fifo_count` update in the same cycle as `count`.
- Reset asserted mid-operation: all state returns to reset values at the next clk edge, and FIFO contents are lost.

## Structure
- Shared package `i2s_pkg`:
  - State enum: IDLE, SYNC, RUN, PUSH2.
  - `CH_MODE_*` constants.
  - Sample width constant `I2S_SAMPLE_W`=24.
- Sub-module `sync_fifo`: parameterised width and depth, with push, pop, flush, full, empty and count. The overflow decision stays in the controller.
- Top level contains the edge detector, decimation counter and FSM.

## Test plan
- Enable, mode 0, decim 0, frames 0x55667788ABCDEFAB then 0x22334455FBABABAB:
  - The first frame is discarded (SYNC).
  - Second frame → one entry: data 0xABABAB, ch 0.
- Mode 2, frame 0xBABABABA55667788 after sync → two entries in order: (0x667788, ch 0) then (0xBABABA, ch 1), written on consecutive cycles.
- Mode 1, decim 2, six kept-eligible frames after sync → exactly frames 1 and 4 pushed, each with ch 1.
- `out_ready`=0, mode 2, `DEPTH`=8, five frames → `fifo_count`=8, `ovf`=1 after the 9th push attempt, and the FIFO still holds the first 8 entries in order.
  - Then `clr_ovf` → `ovf`=0.
  - Then `flush` → count 0.
- `thresh`=3, mode 0 → `level_irq` rises on the cycle `count` becomes 3 and falls after one pop.
  - `thresh`=0 → `level_irq` stays 0.
- `rst_n`=0 during PUSH2 → next cycle all outputs are at reset values and `busy`=0. Also check `en` dropping in RUN → IDLE with FIFO contents kept.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared states, channel-mode codes and sample width for the I2S capture path
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, RUN, PUSH2} state_e;
  localparam logic [1:0] CH_MODE_CH0  = 2'd0;
  localparam logic [1:0] CH_MODE_CH1  = 2'd1;
  localparam logic [1:0] CH_MODE_BOTH = 2'd2;
  localparam logic [1:0] CH_MODE_RSVD = 2'd3;
  localparam int I2S_SAMPLE_W = 24;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular buffer with separate count register, flush, and zeroed head when empty
module sync_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full  = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign dout  = empty ? '0 : mem[rptr];
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(wr) - CNT_W'(rd);
    end
  end
endmodule

// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl: frame capture, channel select and decimation from i2s_rx into a sample FIFO
module i2s_capture_ctrl
  import i2s_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              ch_mode,
  input  logic [3:0]              decim,
  input  logic [CNT_W-1:0]        thresh,
  input  logic                    flush,
  input  logic                    clr_ovf,
  input  logic                    ws,
  input  logic [63:0]             rx_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [I2S_SAMPLE_W-1:0] out_data,
  output logic                    out_ch,
  output logic [CNT_W-1:0]        fifo_count,
  output logic                    level_irq,
  output logic                    ovf,
  output logic                    busy
);
  localparam int EW = I2S_SAMPLE_W + 1;
  state_e state, state_nx;
  logic ws_q, frame_done, keep, push, full, empty;
  logic [3:0] dcnt;
  logic [1:0] mode;
  logic [I2S_SAMPLE_W-1:0] ch1_q;
  logic [EW-1:0] push_data, head;
  assign frame_done = ws & ~ws_q;
  assign mode       = ch_mode == CH_MODE_RSVD ? CH_MODE_CH0 : ch_mode;
  assign keep       = state == RUN && en && frame_done && dcnt == '0;
  assign out_valid  = ~empty;
  assign out_ch     = head[EW-1];
  assign out_data   = head[I2S_SAMPLE_W-1:0];
  assign level_irq  = thresh != '0 && fifo_count >= thresh;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = en ? SYNC : IDLE;
      SYNC:    state_nx = !en ? IDLE : frame_done ? RUN : SYNC;
      RUN:     state_nx = !en ? IDLE : (keep && mode == CH_MODE_BOTH) ? PUSH2 : RUN;
      default: state_nx = en ? RUN : IDLE;
    endcase
  end
  always_comb begin
    push      = keep || state == PUSH2;
    push_data = state == PUSH2 ? {1'b1, ch1_q} :
                mode == CH_MODE_CH1 ? {1'b1, rx_data[55:32]} : {1'b0, rx_data[23:0]};
    busy      = state != IDLE;
  end
  // Overflow is judged on the registered count, so a same-cycle pop cannot rescue a push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ws_q  <= 1'b0;
      dcnt  <= '0;
      ch1_q <= '0;
      ovf   <= 1'b0;
    end else begin
      ws_q <= ws;
      if (state == SYNC && en && frame_done) dcnt <= '0;
      else if (state == RUN && en && frame_done) dcnt <= dcnt != '0 ? dcnt - 4'd1 : decim;
      if (keep) ch1_q <= rx_data[55:32];
      ovf <= (push & full) | (ovf & ~clr_ovf);
    end
  end
  sync_fifo #(.W(EW), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push & ~full),
    .pop   (out_valid & out_ready),
    .flush (flush),
    .din   (push_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// tb_i2s_capture_ctrl: directed and randomized frames checked against a queue-based capture model
module tb_i2s_capture_ctrl;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  logic clk = 0, rst_n = 0, en = 0, flush = 0, clr_ovf = 0, ws = 0, out_ready = 0;
  logic [1:0] ch_mode = 0;
  logic [3:0] decim = 0;
  logic [CNT_W-1:0] thresh = 0;
  logic [63:0] rx_data = 0;
  logic out_valid, out_ch, level_irq, ovf, busy;
  logic [23:0] out_data;
  logic [CNT_W-1:0] fifo_count;
  int n_cmp = 0, n_bad = 0;
  logic [24:0] q[$];
  bit synced, ovf_m;
  int k;
  logic [CNT_W-1:0] c1, c2;

  i2s_capture_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mode(ch_mode), .decim(decim), .thresh(thresh),
    .flush(flush), .clr_ovf(clr_ovf), .ws(ws), .rx_data(rx_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .fifo_count(fifo_count),
    .level_irq(level_irq), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic ch, input logic [23:0] d);
    if (q.size() >= DEPTH) ovf_m = 1;
    else q.push_back({ch, d});
  endtask

  task automatic send_frame(input logic [63:0] d);
    int m;
    ws = 0;
    repeat (3) tick();
    ws = 1;
    rx_data = d;
    tick();
    c1 = fifo_count;
    tick();
    c2 = fifo_count;
    tick();
    tick();
    if (en) begin
      if (!synced) synced = 1;
      else begin
        m = (ch_mode == 3) ? 0 : int'(ch_mode);
        if (k % (int'(decim) + 1) == 0) begin
          if (m == 1) model_push(1'b1, d[55:32]);
          else model_push(1'b0, d[23:0]);
          if (m == 2) model_push(1'b1, d[55:32]);
        end
        k++;
      end
    end
  endtask

  task automatic restart();
    en = 0;
    tick();
    tick();
    en = 1;
    synced = 0;
    k = 0;
    tick();
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    out_ready = 1;
    while (q.size() != 0) begin
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_entry"}, {7'd0, out_ch, out_data}, 32'(q[0]));
      void'(q.pop_front());
      tick();
    end
    out_ready = 0;
    chk({tag, "_empty"}, 32'(out_valid), 0);
  endtask

  task automatic pulse_clr();
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    ovf_m = 0;
    chk("clr_ovf", 32'(ovf), 0);
  endtask

  initial begin
    synced = 0; ovf_m = 0; k = 0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_irq", 32'(level_irq), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;
    tick();
    restart();
    chk("busy_on", 32'(busy), 1);
    send_frame(64'h55667788ABCDEFAB);
    chk("sync_discard", 32'(fifo_count), 0);
    send_frame(64'h22334455FBABABAB);
    chk("m0_count", 32'(fifo_count), 1);
    chk("m0_entry", {7'd0, out_ch, out_data}, 32'h0ABABAB);
    drain("m0");
    ch_mode = 2;
    restart();
    send_frame({$urandom, $urandom});
    send_frame(64'hBABABABA55667788);
    chk("m2_first_cycle", 32'(c1), 1);
    chk("m2_second_cycle", 32'(c2), 2);
    chk("m2_head", {7'd0, out_ch, out_data}, 32'h0667788);
    drain("m2");
    ch_mode = 1;
    decim = 2;
    restart();
    for (int i = 0; i < 7; i++) send_frame({$urandom, $urandom});
    chk("dec2_count", 32'(fifo_count), 2);
    drain("dec2");
    ch_mode = 2;
    decim = 0;
    restart();
    for (int i = 0; i < 6; i++) send_frame({$urandom, $urandom});
    chk("ovf_count", 32'(fifo_count), 8);
    chk("ovf_set", 32'(ovf), 32'(ovf_m));
    chk("ovf_model", 32'(ovf_m), 1);
    pulse_clr();
    drain("ovf");
    send_frame({$urandom, $urandom});
    chk("pre_flush", 32'(fifo_count), 2);
    flush = 1;
    tick();
    flush = 0;
    q.delete();
    chk("flush_count", 32'(fifo_count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    ch_mode = 0;
    thresh = 3;
    restart();
    send_frame({$urandom, $urandom});
    send_frame({$urandom, $urandom});
    send_frame({$urandom, $urandom});
    chk("irq_below", 32'(level_irq), 0);
    ws = 0;
    repeat (3) tick();
    rx_data = {$urandom, $urandom};
    ws = 1;
    tick();
    chk("irq_rise", 32'(level_irq), 1);
    q.push_back({1'b0, rx_data[23:0]});
    k++;
    out_ready = 1;
    tick();
    out_ready = 0;
    void'(q.pop_front());
    chk("irq_fall", 32'(level_irq), 0);
    thresh = 0;
    #1;
    chk("irq_zero_thresh", 32'(level_irq), 0);
    drain("irq");
    for (int s = 0; s < 5; s++) begin
      ch_mode = 2'($urandom_range(0, 3));
      decim = 4'($urandom_range(0, 3));
      restart();
      for (int i = $urandom_range(3, 7); i > 0; i--) send_frame({$urandom, $urandom});
      chk("rnd_ovf", 32'(ovf), 32'(ovf_m));
      if (ovf_m) pulse_clr();
      drain("rnd");
    end
    ch_mode = 0;
    decim = 0;
    restart();
    send_frame({$urandom, $urandom});
    send_frame({$urandom, $urandom});
    en = 0;
    tick();
    tick();
    chk("en_off_busy", 32'(busy), 0);
    send_frame({$urandom, $urandom});
    chk("en_off_kept", 32'(fifo_count), 1);
    drain("en_off");
    ch_mode = 2;
    restart();
    send_frame({$urandom, $urandom});
    send_frame({$urandom, $urandom});
    ws = 0;
    repeat (3) tick();
    ws = 1;
    tick();
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 0;
    tick();
    q.delete();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_irq", 32'(level_irq), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
